l1_cache_controller: RTL

- Direct-mapped, write-back, write-allocate byte cache that sits between the CPU byte port and main memory.
- Initiator side of the main-memory block protocol: request/we/addr/din out, ready/dout in. Blocks are 32 bits, made of four 8-bit words.
- Serves CPU byte reads and writes from a small line store. On a miss it issues one memory write (dirty victim only), then one memory read (refill).

---
 rtl/l1_cache_pkg.sv | 31 +++
 rtl/cache_line_store.sv | 53 +++++
 rtl/l1_cache_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/l1_cache_pkg.sv
// Shared types, widths and address-field helpers for the L1 byte cache.
package l1_cache_pkg;

  localparam int BLK_ADDR_W = 6;
  localparam int NUM_LINES  = 4;
  localparam int IDX_W      = $clog2(NUM_LINES);
  localparam int TAG_W      = BLK_ADDR_W - IDX_W;
  localparam int WORD_W     = 8;
  localparam int BLK_W      = 4 * WORD_W;
  localparam int ADDR_W     = BLK_ADDR_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  function automatic logic [1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[1:0];
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/dirty/tag/data arrays: combinational read by index, synchronous
// byte write or full-line fill at the same index.
module cache_line_store
  import l1_cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [BLK_W-1:0]  data_o,
  input  logic              wr_byte_en_i,
  input  logic [1:0]        wr_off_i,
  input  logic [WORD_W-1:0] wr_byte_i,
  input  logic              fill_en_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [BLK_W-1:0]  fill_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLK_W-1:0]     data_q [NUM_LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (wr_byte_en_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: nothing reads them while valid is clear.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_data_i;
    end else if (wr_byte_en_i) begin
      data_q[idx_i][int'(wr_off_i)*WORD_W +: WORD_W] <= wr_byte_i;
    end
  end

endmodule

// File: rtl/l1_cache_controller.sv
// Direct-mapped write-back/write-allocate byte cache controller: CPU byte
// port on one side, block-wide main-memory initiator on the other.
module l1_cache_controller
  import l1_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_request,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [WORD_W-1:0]     cpu_din,
  output logic                  cpu_ready,
  output logic [WORD_W-1:0]     cpu_dout,
  output logic                  m_request,
  output logic                  m_we,
  output logic [BLK_ADDR_W-1:0] m_addr,
  output logic [BLK_W-1:0]      m_din,
  input  logic                  m_ready,
  input  logic [BLK_W-1:0]      m_dout
);

  state_e              state_q, state_d;
  logic                first_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [WORD_W-1:0]   din_q, din_d;

  logic                line_valid, line_dirty, hit, mem_done;
  logic [TAG_W-1:0]    line_tag;
  logic [BLK_W-1:0]    line_data;
  logic                wr_byte_en, fill_en;
  logic [IDX_W-1:0]    idx;

  assign idx      = addr_idx(addr_q);
  assign hit      = line_valid && (line_tag == addr_tag(addr_q));
  // Ready in the first cycle of a memory state belongs to the previous transaction.
  assign mem_done = m_ready && !first_q;

  cache_line_store u_store (
    .clk          (clk),
    .reset        (reset),
    .idx_i        (idx),
    .valid_o      (line_valid),
    .dirty_o      (line_dirty),
    .tag_o        (line_tag),
    .data_o       (line_data),
    .wr_byte_en_i (wr_byte_en),
    .wr_off_i     (addr_off(addr_q)),
    .wr_byte_i    (din_q),
    .fill_en_i    (fill_en),
    .fill_tag_i   (addr_tag(addr_q)),
    .fill_data_i  (m_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
      addr_q  <= addr_d;
      we_q    <= we_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    din_d      = din_q;
    cpu_ready  = 1'b0;
    cpu_dout   = '0;
    m_request  = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_din      = '0;
    wr_byte_en = 1'b0;
    fill_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_request) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          din_d   = cpu_din;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          cpu_ready = 1'b1;
          if (we_q) wr_byte_en = 1'b1;
          else      cpu_dout   = line_data[int'(addr_off(addr_q))*WORD_W +: WORD_W];
          state_d = IDLE;
        end else if (line_valid && line_dirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        m_request = 1'b1;
        m_we      = 1'b1;
        m_addr    = {line_tag, idx};
        m_din     = line_data;
        if (mem_done) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        m_request = 1'b1;
        m_addr    = {addr_tag(addr_q), idx};
        if (mem_done) begin
          fill_en = 1'b1;
          state_d = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
